uart_sim_dual: RTL

//  Parametrised simulation UART with a TX FIFO of configurable depth and drain rate, plus a

---
 rtl/uart_sim_dual.sv | 112 +++++++++++
 1 files changed

// File: rtl/uart_sim_dual.sv
// uart_sim_dual: simulation UART with a rate-limited TX FIFO and a bench-fed RX FIFO.
// Ports: clk/resetn (async active-low); write_fifo/write_data push TX bytes;
//   read_state/read_sel request a registered read (0: status, 1: RX pop), answered on
//   read_ok/read_data one cycle later; rx_push/rx_data inject RX bytes;
//   tx_valid/tx_data pulse once per byte drained from the TX FIFO.
module uart_sim_dual #(
  parameter int UART_SIM  = 1,
  parameter int TX_DEPTH  = 16,
  parameter int RX_DEPTH  = 8,
  parameter int DRAIN_DIV = 128
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        write_fifo,
  input  logic [7:0]  write_data,
  input  logic        read_state,
  input  logic        read_sel,
  output logic        read_ok,
  output logic [31:0] read_data,
  input  logic        rx_push,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data
);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int DW  = $clog2(DRAIN_DIV) + 1;
  logic [7:0]    tx_mem [TX_DEPTH];
  logic [7:0]    rx_mem [RX_DEPTH];
  logic [TAW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [TAW:0]   tx_cnt_q, tx_cnt_d;
  logic [RAW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [RAW:0]   rx_cnt_q, rx_cnt_d;
  logic [DW-1:0]  div_q, div_d;
  logic           tx_ovr_q, tx_ovr_d, rx_ovr_q, rx_ovr_d;
  logic           read_ok_q, read_ok_d, tx_valid_q, tx_valid_d;
  logic [31:0]    read_data_q, read_data_d;
  logic [7:0]     tx_data_q, tx_data_d;
  logic           slot, tx_pop, tx_full, tx_push, rx_pop, rx_full, rx_acc, stat_rd;
  logic [31:0]    status;
  always_comb begin
    slot    = div_q == DW'(DRAIN_DIV - 1);
    tx_pop  = slot && (tx_cnt_q != '0);
    tx_full = tx_cnt_q == (TAW+1)'(TX_DEPTH);
    // a full FIFO still accepts a byte on the edge that frees a slot
    tx_push = write_fifo && (!tx_full || tx_pop);
    rx_full = rx_cnt_q == (RAW+1)'(RX_DEPTH);
    rx_pop  = read_state && read_sel && (rx_cnt_q != '0);
    rx_acc  = rx_push && (!rx_full || rx_pop);
    stat_rd = read_state && !read_sel;
    div_d    = slot ? '0 : div_q + 1'b1;
    tx_wp_d  = tx_wp_q + TAW'(tx_push);
    tx_rp_d  = tx_rp_q + TAW'(tx_pop);
    tx_cnt_d = tx_cnt_q + (TAW+1)'(tx_push) - (TAW+1)'(tx_pop);
    rx_wp_d  = rx_wp_q + RAW'(rx_acc);
    rx_rp_d  = rx_rp_q + RAW'(rx_pop);
    rx_cnt_d = rx_cnt_q + (RAW+1)'(rx_acc) - (RAW+1)'(rx_pop);
    // a new overrun beats the clear-on-read of the status word
    tx_ovr_d = (write_fifo && !tx_push) || (tx_ovr_q && !stat_rd);
    rx_ovr_d = (rx_push && !rx_acc) || (rx_ovr_q && !stat_rd);
    // tx_full stays at bit 3 so existing firmware polling keeps working
    status = {8'h0, 8'(rx_cnt_q), 8'(tx_cnt_q), 2'b0, rx_ovr_q, tx_ovr_q,
              tx_full, tx_cnt_q == '0, rx_full, rx_cnt_q != '0};
    read_ok_d   = read_state;
    read_data_d = !read_state ? 32'h0 :
                  read_sel ? {24'h0, rx_pop ? rx_mem[rx_rp_q] : 8'h0} : status;
    tx_valid_d  = tx_pop;
    tx_data_d   = tx_pop ? tx_mem[tx_rp_q] : 8'h0;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_wp_q     <= '0;
      tx_rp_q     <= '0;
      tx_cnt_q    <= '0;
      rx_wp_q     <= '0;
      rx_rp_q     <= '0;
      rx_cnt_q    <= '0;
      div_q       <= '0;
      tx_ovr_q    <= 1'b0;
      rx_ovr_q    <= 1'b0;
      read_ok_q   <= 1'b0;
      read_data_q <= '0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
    end else begin
      tx_wp_q     <= tx_wp_d;
      tx_rp_q     <= tx_rp_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_wp_q     <= rx_wp_d;
      rx_rp_q     <= rx_rp_d;
      rx_cnt_q    <= rx_cnt_d;
      div_q       <= div_d;
      tx_ovr_q    <= tx_ovr_d;
      rx_ovr_q    <= rx_ovr_d;
      read_ok_q   <= read_ok_d;
      read_data_q <= read_data_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
    end
  end
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp_q] <= write_data;
    if (rx_acc) rx_mem[rx_wp_q] <= rx_data;
  end
`ifndef SYNTHESIS
  always @(posedge clk) if (UART_SIM != 0 && resetn && tx_pop) $write("%c", tx_mem[tx_rp_q]);
`endif
  assign read_ok   = read_ok_q;
  assign read_data = read_data_q;
  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
endmodule
